// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 16
);
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic [REGW-1:0] idex_rt;
    logic            idex_memread;
    logic [REGW-1:0] idex_rs_fw;
    logic [REGW-1:0] idex_rt_fw;
    logic [REGW-1:0] exmem_wreg;
    logic [REGW-1:0] memwb_wreg;
    logic            exmem_regwrite;
    logic            memwb_regwrite;
    logic [REGW-1:0] idex_wreg;
    logic            idex_regwrite;
    logic            exmem_memacc;
    logic            dmem_ready;
    logic            branch_taken;
    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            exmem_hold;
    logic            memwb_hold;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, idex_rt, idex_memread,
               idex_rs_fw, idex_rt_fw, exmem_wreg, memwb_wreg, exmem_regwrite,
               memwb_regwrite, idex_wreg, idex_regwrite, exmem_memacc,
               dmem_ready, branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold,
               memwb_hold, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, idex_rt, idex_memread,
               idex_rs_fw, idex_rt_fw, exmem_wreg, memwb_wreg, exmem_regwrite,
               memwb_regwrite, idex_wreg, idex_regwrite, exmem_memacc,
               dmem_ready, branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold,
               memwb_hold, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze, load-use/RAW stall, branch flush, forwarding.
// HAZARD_FWD_EN defined: EX-stage forwarding; undefined: forwarding tied off and RAW hazards stall in ID.
module pipeline_hazard_ctrl #(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 16
) (
    input logic                 Clk,
    input logic                 Rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            br_pend_q, br_pend_d;
    logic [CNTW-1:0] stall_cnt_q;
    logic            freeze, load_use, raw_stall, data_stall, branch_req;
    logic            pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_hold;
    logic [1:0]      fwd_a, fwd_b;

    function automatic logic src_hit(input logic used, input logic [REGW-1:0] src,
                                     input logic we, input logic [REGW-1:0] wreg);
        return used && we && (wreg != REGW'(0)) && (src == wreg);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src,
                                           input logic ex_we, input logic [REGW-1:0] ex_wreg,
                                           input logic wb_we, input logic [REGW-1:0] wb_wreg);
        if (src_hit(1'b1, src, ex_we, ex_wreg)) return 2'b10;
        if (src_hit(1'b1, src, wb_we, wb_wreg)) return 2'b01;
        return 2'b00;
    endfunction

    // Hazard detection; every hazard is masked while in reset so outputs show normal flow.
    always_comb begin
        freeze   = Rst_n && !hz.dmem_ready && ((state_q == WAIT) || hz.exmem_memacc);
        load_use = hz.idex_memread &&
                   (src_hit(hz.id_use_rs, hz.id_rs, 1'b1, hz.idex_rt) ||
                    src_hit(hz.id_use_rt, hz.id_rt, 1'b1, hz.idex_rt));
`ifdef HAZARD_FWD_EN
        raw_stall = 1'b0;
`else
        raw_stall = src_hit(hz.id_use_rs, hz.id_rs, hz.idex_regwrite, hz.idex_wreg) ||
                    src_hit(hz.id_use_rt, hz.id_rt, hz.idex_regwrite, hz.idex_wreg) ||
                    src_hit(hz.id_use_rs, hz.id_rs, hz.exmem_regwrite, hz.exmem_wreg) ||
                    src_hit(hz.id_use_rt, hz.id_rt, hz.exmem_regwrite, hz.exmem_wreg);
`endif
        data_stall = Rst_n && (load_use || raw_stall);
        branch_req = Rst_n && (hz.branch_taken || br_pend_q);
    end

    // Memory-wait FSM; WAIT releases in the cycle dmem_ready returns so the completing access advances.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hz.exmem_memacc && !hz.dmem_ready) state_d = WAIT;
            WAIT:    if (hz.dmem_ready) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Stage control with priority freeze > data stall > flush; a blocked branch is remembered.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        memwb_hold  = 1'b0;
        br_pend_d   = br_pend_q;
        if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            memwb_hold = 1'b1;
            br_pend_d  = br_pend_q || hz.branch_taken;
        end else if (data_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            br_pend_d   = br_pend_q || hz.branch_taken;
        end else if (branch_req) begin
            ifid_flush = 1'b1;
            br_pend_d  = 1'b0;
        end
    end

    always_comb begin
`ifdef HAZARD_FWD_EN
        fwd_a = fwd_sel(hz.idex_rs_fw, hz.exmem_regwrite, hz.exmem_wreg,
                        hz.memwb_regwrite, hz.memwb_wreg);
        fwd_b = fwd_sel(hz.idex_rt_fw, hz.exmem_regwrite, hz.exmem_wreg,
                        hz.memwb_regwrite, hz.memwb_wreg);
`else
        fwd_a = 2'b00;
        fwd_b = 2'b00;
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= RUN;
            br_pend_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            br_pend_q <= br_pend_d;
            if (!pc_write && (stall_cnt_q != {CNTW{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.exmem_hold  = exmem_hold;
    assign hz.memwb_hold  = memwb_hold;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus multi-cycle stall/wait/branch/reset sequences.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned REGW = 5;
    localparam int unsigned CNTW = 6;
`ifdef HAZARD_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif
    // ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_hold}
    localparam logic [5:0] NORM = 6'b110000;
    localparam logic [5:0] LU   = 6'b000100;
    localparam logic [5:0] FLSH = 6'b111000;
    localparam logic [5:0] FRZ  = 6'b000011;

    typedef struct {
        string           name;
        logic [REGW-1:0] id_rs, id_rt;
        logic            use_rs, use_rt, memread;
        logic [REGW-1:0] idex_rt, idex_wreg, exmem_wreg, memwb_wreg, rs_fw, rt_fw;
        logic            idex_we, exmem_we, memwb_we, br, raw;
        logic [5:0]      ctl;
        logic [1:0]      fa, fb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    pipeline_hazard_ctrl_if #(.REGW(REGW), .CNTW(CNTW)) hz ();
    pipeline_hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (.Clk(clk), .Rst_n(rst_n), .hz(hz));

    always #5 clk = ~clk;

    function automatic vec_t mkv(input string name,
            input logic [4:0] id_rs, input logic use_rs, input logic [4:0] id_rt, input logic use_rt,
            input logic memread, input logic [4:0] idex_rt,
            input logic [4:0] idex_wreg, input logic idex_we,
            input logic [4:0] exmem_wreg, input logic exmem_we,
            input logic [4:0] memwb_wreg, input logic memwb_we,
            input logic [4:0] rs_fw, input logic [4:0] rt_fw, input logic br, input logic raw,
            input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.name = name; v.id_rs = id_rs; v.use_rs = use_rs; v.id_rt = id_rt; v.use_rt = use_rt;
        v.memread = memread; v.idex_rt = idex_rt; v.idex_wreg = idex_wreg; v.idex_we = idex_we;
        v.exmem_wreg = exmem_wreg; v.exmem_we = exmem_we; v.memwb_wreg = memwb_wreg;
        v.memwb_we = memwb_we; v.rs_fw = rs_fw; v.rt_fw = rt_fw; v.br = br; v.raw = raw;
        v.ctl = ctl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic clr_in();
        hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 0; hz.id_use_rt = 0;
        hz.idex_rt = '0; hz.idex_memread = 0; hz.idex_rs_fw = '0; hz.idex_rt_fw = '0;
        hz.exmem_wreg = '0; hz.memwb_wreg = '0; hz.exmem_regwrite = 0; hz.memwb_regwrite = 0;
        hz.idex_wreg = '0; hz.idex_regwrite = 0; hz.exmem_memacc = 0; hz.dmem_ready = 1;
        hz.branch_taken = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input logic [5:0] exp);
        chk(name, 32'({hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble,
                       hz.exmem_hold, hz.memwb_hold}), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_in();
        rst_n = 1'b0;
        #1 chk("rst_cnt", 32'(hz.stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_lu(input logic on);
        hz.idex_memread = on; hz.idex_rt = 5'd8; hz.id_rs = 5'd8; hz.id_use_rs = 1'b1;
    endtask

    initial begin
        //          name       rs use rt use mrd irt iwr iwe ewr ewe wwr wwe rsf rtf br raw ctl  fa     fb
        vecs.push_back(mkv("idle",     0,0, 0,0, 0, 0, 0,0, 0,0, 0,0, 0,0, 0,0, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("lu_rs",    8,1, 0,0, 1, 8, 0,0, 0,0, 0,0, 0,0, 0,0, LU,   2'b00,2'b00));
        vecs.push_back(mkv("lu_rt",    0,0, 3,1, 1, 3, 0,0, 0,0, 0,0, 0,0, 0,0, LU,   2'b00,2'b00));
        vecs.push_back(mkv("lu_unused",8,0, 8,0, 1, 8, 0,0, 0,0, 0,0, 0,0, 0,0, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("lu_r0",    0,1, 0,1, 1, 0, 0,0, 0,0, 0,0, 0,0, 0,0, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("lu_nomrd", 8,1, 0,0, 0, 8, 0,0, 0,0, 0,0, 0,0, 0,0, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("branch",   0,0, 0,0, 0, 0, 0,0, 0,0, 0,0, 0,0, 1,0, FLSH, 2'b00,2'b00));
        vecs.push_back(mkv("lu_br",    8,1, 0,0, 1, 8, 0,0, 0,0, 0,0, 0,0, 1,0, LU,   2'b00,2'b00));
        vecs.push_back(mkv("br_pend",  0,0, 0,0, 0, 0, 0,0, 0,0, 0,0, 0,0, 0,0, FLSH, 2'b00,2'b00));
        vecs.push_back(mkv("br_clr",   0,0, 0,0, 0, 0, 0,0, 0,0, 0,0, 0,0, 0,0, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("fwd_ex",   0,0, 0,0, 0, 0, 0,0, 5,1, 5,1, 5,0, 0,0, NORM, 2'b10,2'b00));
        vecs.push_back(mkv("fwd_wb",   0,0, 0,0, 0, 0, 0,0, 5,0, 5,1, 5,0, 0,0, NORM, 2'b01,2'b00));
        vecs.push_back(mkv("fwd_r0",   0,0, 0,0, 0, 0, 0,0, 0,1, 0,1, 0,0, 0,0, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("fwd_ab",   0,0, 0,0, 0, 0, 0,0, 7,1, 7,1, 7,7, 0,0, NORM, 2'b10,2'b10));
        vecs.push_back(mkv("fwd_mix",  0,0, 0,0, 0, 0, 0,0, 4,1,12,1, 4,12,0,0, NORM, 2'b10,2'b01));
        vecs.push_back(mkv("fwd_miss", 0,0, 0,0, 0, 0, 0,0, 4,1, 0,0, 6,0, 0,0, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("raw_idex", 0,0, 9,1, 0, 0, 9,1, 0,0, 0,0, 0,0, 0,1, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("raw_exmem",11,1,0,0, 0, 0, 0,0,11,1, 0,0, 0,0, 0,1, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("raw_memwb",11,1,0,0, 0, 0, 0,0, 0,0,11,1, 0,0, 0,0, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("raw_nowe", 0,0, 9,1, 0, 0, 9,0, 0,0, 0,0, 0,0, 0,0, NORM, 2'b00,2'b00));
        vecs.push_back(mkv("raw_r0",   0,1, 0,0, 0, 0, 0,1, 0,0, 0,0, 0,0, 0,0, NORM, 2'b00,2'b00));

        // Outputs during reset show normal flow despite hazards on the inputs.
        clr_in();
        #2 rst_n = 1'b0;
        hz.exmem_memacc = 1; hz.dmem_ready = 0; hz.branch_taken = 1; set_lu(1'b1);
        hz.exmem_wreg = 5'd5; hz.exmem_regwrite = 1; hz.idex_rs_fw = 5'd5;
        #1;
        chk_ctl("in_reset_ctl", NORM);
        chk("in_reset_fwd_a", 32'(hz.fwd_a), FWD_ON ? 32'd2 : 32'd0);
        chk("in_reset_cnt", 32'(hz.stall_cnt), 32'd0);
        @(negedge clk);
        clr_in();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            clr_in();
            hz.id_rs = vecs[i].id_rs; hz.id_use_rs = vecs[i].use_rs;
            hz.id_rt = vecs[i].id_rt; hz.id_use_rt = vecs[i].use_rt;
            hz.idex_memread = vecs[i].memread; hz.idex_rt = vecs[i].idex_rt;
            hz.idex_wreg = vecs[i].idex_wreg; hz.idex_regwrite = vecs[i].idex_we;
            hz.exmem_wreg = vecs[i].exmem_wreg; hz.exmem_regwrite = vecs[i].exmem_we;
            hz.memwb_wreg = vecs[i].memwb_wreg; hz.memwb_regwrite = vecs[i].memwb_we;
            hz.idex_rs_fw = vecs[i].rs_fw; hz.idex_rt_fw = vecs[i].rt_fw;
            hz.branch_taken = vecs[i].br;
            #1;
            chk_ctl({vecs[i].name, "_ctl"}, (!FWD_ON && vecs[i].raw) ? LU : vecs[i].ctl);
            chk({vecs[i].name, "_fa"}, 32'(hz.fwd_a), FWD_ON ? 32'(vecs[i].fa) : 32'd0);
            chk({vecs[i].name, "_fb"}, 32'(hz.fwd_b), FWD_ON ? 32'(vecs[i].fb) : 32'd0);
        end

        // Single load-use stall, then normal flow.
        do_reset();
        @(negedge clk); set_lu(1'b1);
        #1 chk_ctl("lu_seq_stall", LU);
        @(negedge clk); hz.idex_memread = 1'b0;
        #1 chk_ctl("lu_seq_after", NORM);
        chk("lu_seq_cnt", 32'(hz.stall_cnt), 32'd1);

        // Three-cycle memory wait.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); hz.exmem_memacc = 1'b1; hz.dmem_ready = 1'b0;
            #1 chk_ctl($sformatf("mw_frz%0d", c), FRZ);
        end
        @(negedge clk); hz.dmem_ready = 1'b1;
        #1 chk_ctl("mw_release", NORM);
        @(negedge clk); hz.exmem_memacc = 1'b0; hz.dmem_ready = 1'b0;
        #1 chk_ctl("mw_back_run", NORM);
        chk("mw_cnt", 32'(hz.stall_cnt), 32'd3);

        // Branch during a two-cycle wait flushes once on the first free cycle.
        do_reset();
        @(negedge clk); hz.exmem_memacc = 1'b1; hz.dmem_ready = 1'b0; hz.branch_taken = 1'b1;
        #1 chk_ctl("bw_frz0", FRZ);
        @(negedge clk); hz.branch_taken = 1'b0;
        #1 chk_ctl("bw_frz1", FRZ);
        @(negedge clk); hz.dmem_ready = 1'b1; hz.exmem_memacc = 1'b0;
        #1 chk_ctl("bw_flush", FLSH);
        @(negedge clk);
        #1 chk_ctl("bw_once", NORM);

        // RAW match persisting three cycles.
        do_reset();
        @(negedge clk); hz.idex_wreg = 5'd9; hz.idex_regwrite = 1'b1; hz.id_rt = 5'd9; hz.id_use_rt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk_ctl($sformatf("raw_seq%0d", c), FWD_ON ? NORM : LU);
            @(negedge clk);
        end
        hz.idex_regwrite = 1'b0;
        #1 chk_ctl("raw_seq_end", NORM);
        chk("raw_seq_cnt", 32'(hz.stall_cnt), FWD_ON ? 32'd0 : 32'd3);
        chk("raw_seq_fwd", 32'({hz.fwd_a, hz.fwd_b}), 32'd0);

        // Saturation, then reset asserted mid-WAIT.
        do_reset();
        @(negedge clk); set_lu(1'b1);
        repeat (63) @(posedge clk);
        #1 chk("sat_reach", 32'(hz.stall_cnt), 32'd63);
        repeat (2) @(posedge clk);
        #1 chk("sat_hold", 32'(hz.stall_cnt), 32'd63);
        @(negedge clk); clr_in(); hz.exmem_memacc = 1'b1; hz.dmem_ready = 1'b0; hz.branch_taken = 1'b1;
        #1 chk_ctl("sat_frz0", FRZ);
        @(negedge clk); hz.branch_taken = 1'b0;
        #1 chk_ctl("sat_frz1", FRZ);
        chk("sat_hold_wait", 32'(hz.stall_cnt), 32'd63);
        #2 rst_n = 1'b0;
        #1 chk("rst_wait_cnt", 32'(hz.stall_cnt), 32'd0);
        chk_ctl("rst_wait_ctl", NORM);
        @(negedge clk); rst_n = 1'b1; hz.exmem_memacc = 1'b0; hz.dmem_ready = 1'b0;
        #1 chk_ctl("rst_wait_norun", NORM);
        @(negedge clk);
        #1 chk_ctl("rst_wait_noflush", NORM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REGW, default 5, register-specifier width.
REQ-002 SHALL have parameter CNTW, default 16, stall-counter width.
REQ-003 SHALL have ports: Clk in 1 clock; Rst_n in 1 reset. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: id_rs, id_rt in REGW each (IF/ID source specifiers); id_use_rs, id_use_rt in 1 each (the source is read).
REQ-005 SHALL have ports: idex_rt in REGW; idex_memread in 1 (a load is in EX).
REQ-006 SHALL have ports: idex_rs_fw, idex_rt_fw in REGW each (EX-stage sources); exmem_wreg, memwb_wreg in REGW each; exmem_regwrite, memwb_regwrite in 1 each.
REQ-007 SHALL have ports: idex_wreg in REGW; idex_regwrite in 1 (EX-stage destination).
REQ-008 SHALL have ports: exmem_memacc in 1 (load/store in MEM); dmem_ready in 1 (data memory done); branch_taken in 1 (resolved in ID).
REQ-009 SHALL have outputs: pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_hold, each out 1.
REQ-010 SHALL have outputs: fwd_a, fwd_b out 2 each (00 regfile, 10 EX/MEM, 01 MEM/WB); stall_cnt out CNTW.

Function
REQ-011 SHALL implement FSM states RUN and WAIT.
REQ-012 RUN -> WAIT SHALL occur when exmem_memacc=1 and dmem_ready=0; WAIT -> RUN SHALL occur on the first cycle in which dmem_ready=1.
REQ-013 The freeze condition SHALL be: state=WAIT, or RUN with exmem_memacc=1 and dmem_ready=0.
REQ-014 During freeze: pc_write=0, ifid_write=0, exmem_hold=1, memwb_hold=1, idex_bubble=0, ifid_flush=0.
REQ-015 Load-use hazard SHALL be: idex_memread, idex_rt!=0, and ((id_use_rs, id_rs==idex_rt) or (id_use_rt, id_rt==idex_rt)).
REQ-016 Load-use without freeze SHALL give pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle. The bubble SHALL clear the hazard, because idex_memread then becomes 0.
REQ-017 Branch without freeze or load-use SHALL give ifid_flush=1 in the same cycle; pc_write=1 and ifid_write=1.
REQ-018 A branch_taken seen during freeze or load-use SHALL set the registered flag br_pend. The flush SHALL issue on the first cycle with neither condition, then br_pend SHALL clear.
REQ-019 Priority SHALL be: freeze > load-use > flush.
REQ-020 Otherwise all write enables SHALL be 1 and all hold/flush/bubble outputs 0.
REQ-021 fwd_a SHALL be 10 if exmem_regwrite, exmem_wreg!=0, and exmem_wreg==idex_rs_fw.
REQ-022 Otherwise fwd_a SHALL be 01 if memwb_regwrite, memwb_wreg!=0, and memwb_wreg==idex_rs_fw; else 00. fwd_b SHALL be the same using idex_rt_fw.
REQ-023 stall_cnt SHALL increment by 1 per cycle in which pc_write=0, saturating at all-ones with no wrap.
REQ-024 Register 0 SHALL never create a hazard or a forward.
REQ-025 All control outputs SHALL be combinational from the current state, br_pend and the inputs; only the state, br_pend and stall_cnt are registered.

Reset
REQ-026 Rst_n=0 SHALL immediately force state=RUN, br_pend=0, stall_cnt=0.
REQ-027 While Rst_n=0, outputs SHALL follow REQ-020/021 from the inputs.
REQ-028 Reset mid-WAIT SHALL abandon the wait without a flush.

Configuration
REQ-029 Macro HAZARD_FWD_EN defined: forwarding SHALL be per REQ-021/022.
REQ-030 Without the macro, fwd_a and fwd_b SHALL be tied to 00, and RAW-stall detection SHALL be added.
REQ-031 The added RAW stall SHALL trigger when an ID source used (id_use_rs/id_use_rt) matches a nonzero idex_wreg with idex_regwrite=1, or a nonzero exmem_wreg with exmem_regwrite=1.
REQ-032 The RAW stall SHALL be treated as load-use (REQ-016/018/019) and repeat each cycle while the match persists. MEM/WB matches are not stalled; the register file writes before it reads.

Verification
REQ-033 Load-use: idex_memread=1, idex_rt=8, id_rs=8, id_use_rs=1 -> one cycle with pc_write=0, idex_bubble=1, then normal flow; stall_cnt=1.
REQ-034 Memory wait: exmem_memacc=1, dmem_ready=0 for 3 cycles, then 1 -> pc_write=0 and exmem_hold=1 for 3 cycles, WAIT exited, stall_cnt=3.
REQ-035 Branch during WAIT: branch_taken=1 pulsed in cycle 1 of a 2-cycle wait -> ifid_flush=1 on the first RUN cycle only.
REQ-036 Forwarding (macro on): exmem_wreg=memwb_wreg=5, both regwrite=1, idex_rs_fw=5 -> fwd_a=10; exmem_regwrite=0 -> fwd_a=01; wreg=0 -> fwd_a=00.
REQ-037 Macro off: idex_wreg=9, idex_regwrite=1, id_rt=9, id_use_rt=1 -> stalls until no match; fwd_a=fwd_b=00 always.
REQ-038 Saturation and reset: drive stall_cnt to all-ones, then stall again -> holds at all-ones; assert Rst_n=0 in WAIT -> RUN and stall_cnt=0 immediately.
